// File: rtl/dds_sweep_ctrl.sv
// Frequency/phase sweep controller feeding the DDS core.
// Steps fword through [f_min, f_max] with a per-word dwell and advances pword on every step.
module dds_sweep_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [1:0]             mode,
    input  logic [2:0]             f_min,
    input  logic [2:0]             f_max,
    input  logic [DWELL_WIDTH-1:0] dwell,
    input  logic [ADDR_WIDTH-1:0]  p_step,
    output logic [2:0]             fword,
    output logic [ADDR_WIDTH-1:0]  pword,
    output logic                   busy,
    output logic                   step_tick,
    output logic                   done,
    output logic                   cfg_err,
    output logic                   state_dbg
);

    // STEP is zero-length, so it exists only as the dwell-expiry branch of RUN.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_WRAP = 2'b10;
    localparam logic [1:0] MODE_PING = 2'b11;

    state_t                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [2:0]             fmin_q, fmin_d;
    logic [2:0]             fmax_q, fmax_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [ADDR_WIDTH-1:0]  pstep_q, pstep_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic                   dir_up_q, dir_up_d;
    logic [2:0]             fword_d;
    logic [ADDR_WIDTH-1:0]  pword_d;
    logic                   busy_d, step_tick_d, done_d, cfg_err_d;

    logic [DWELL_WIDTH-1:0] dwell_last;
    logic                   expire;
    logic                   cfg_ok;
    logic [2:0]             next_word;
    logic                   next_dir_up;
    logic                   finish;

    assign cfg_ok     = (f_min != 3'd0) && (f_min <= f_max);
    // Dwell of 0 behaves as 1, so the terminal count is 0 in both cases.
    assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - 1'b1;
    assign expire     = (cnt_q == dwell_last);
    assign state_dbg  = state_q;

    always_comb begin
        next_word   = fword;
        next_dir_up = dir_up_q;
        finish      = 1'b0;
        case (mode_q)
            MODE_UP: begin
                finish    = (fword == fmax_q);
                next_word = fword + 3'd1;
            end
            MODE_DOWN: begin
                finish    = (fword == fmin_q);
                next_word = fword - 3'd1;
            end
            MODE_WRAP: begin
                next_word = (fword == fmax_q) ? fmin_q : fword + 3'd1;
            end
            default: begin
                // Turn around on the endpoint itself so it is held only once per pass.
                if (fmin_q == fmax_q) begin
                    next_word = fword;
                end else if (dir_up_q) begin
                    if (fword == fmax_q) begin
                        next_word   = fword - 3'd1;
                        next_dir_up = 1'b0;
                    end else begin
                        next_word = fword + 3'd1;
                    end
                end else begin
                    if (fword == fmin_q) begin
                        next_word   = fword + 3'd1;
                        next_dir_up = 1'b1;
                    end else begin
                        next_word = fword - 3'd1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        fmin_d      = fmin_q;
        fmax_d      = fmax_q;
        dwell_d     = dwell_q;
        pstep_d     = pstep_q;
        cnt_d       = cnt_q;
        dir_up_d    = dir_up_q;
        fword_d     = fword;
        pword_d     = pword;
        busy_d      = busy;
        step_tick_d = 1'b0;
        done_d      = 1'b0;
        cfg_err_d   = cfg_err;
        case (state_q)
            IDLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    if (cfg_ok) begin
                        state_d     = RUN;
                        mode_d      = mode;
                        fmin_d      = f_min;
                        fmax_d      = f_max;
                        dwell_d     = dwell;
                        pstep_d     = p_step;
                        cnt_d       = '0;
                        dir_up_d    = (mode != MODE_DOWN);
                        fword_d     = (mode == MODE_DOWN) ? f_max : f_min;
                        pword_d     = '0;
                        busy_d      = 1'b1;
                        step_tick_d = 1'b1;
                        cfg_err_d   = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    fword_d = 3'd0;
                    busy_d  = 1'b0;
                end else if (expire) begin
                    cnt_d = '0;
                    if (finish) begin
                        state_d = IDLE;
                        fword_d = 3'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        fword_d     = next_word;
                        dir_up_d    = next_dir_up;
                        pword_d     = pword + pstep_q;
                        step_tick_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= 2'b00;
            fmin_q    <= 3'd0;
            fmax_q    <= 3'd0;
            dwell_q   <= '0;
            pstep_q   <= '0;
            cnt_q     <= '0;
            dir_up_q  <= 1'b1;
            fword     <= 3'd0;
            pword     <= '0;
            busy      <= 1'b0;
            step_tick <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            fmin_q    <= fmin_d;
            fmax_q    <= fmax_d;
            dwell_q   <= dwell_d;
            pstep_q   <= pstep_d;
            cnt_q     <= cnt_d;
            dir_up_q  <= dir_up_d;
            fword     <= fword_d;
            pword     <= pword_d;
            busy      <= busy_d;
            step_tick <= step_tick_d;
            done      <= done_d;
            cfg_err   <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: hand-computed sequences checked with immediate assertions.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [2:0]  f_min = 3'd0;
    logic [2:0]  f_max = 3'd0;
    logic [15:0] dwell = 16'd0;
    logic [11:0] p_step = 12'd0;
    logic [2:0]  fword;
    logic [11:0] pword;
    logic        busy, step_tick, done, cfg_err, state_dbg;

    int checks = 0;
    int errors = 0;

    dds_sweep_ctrl #(.ADDR_WIDTH(12), .DWELL_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .f_min(f_min), .f_max(f_max), .dwell(dwell), .p_step(p_step),
        .fword(fword), .pword(pword), .busy(busy), .step_tick(step_tick),
        .done(done), .cfg_err(cfg_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Advance one edge, then settle so registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] m, input logic [2:0] lo, input logic [2:0] hi,
                       input logic [15:0] d, input logic [11:0] ps);
        mode = m; f_min = lo; f_max = hi; dwell = d; p_step = ps;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [2:0]  pp_seq [8];
    logic [11:0] wrap_p [5];
    logic [2:0]  wrap_f [5];

    initial begin
        pp_seq = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd2};
        wrap_p = '{12'h000, 12'hC00, 12'h800, 12'h400, 12'h000};
        wrap_f = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1};

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_fword", fword, 0);
        chk("rst_pword", pword, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick", step_tick, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_state", state_dbg, 0);

        // Single up 2..5, dwell 3, p_step 100; a second start mid-sweep is ignored
        cfg(2'b00, 3'd2, 3'd5, 16'd3, 12'd100);
        pulse_start();
        for (int k = 0; k < 12; k++) begin
            chk("up_fword", fword, 2 + k / 3);
            chk("up_pword", pword, 100 * (k / 3));
            chk("up_busy", busy, 1);
            chk("up_tick", step_tick, (k % 3 == 0) ? 1 : 0);
            chk("up_done", done, 0);
            if (k == 4) begin
                cfg(2'b11, 3'd1, 3'd7, 16'd1, 12'd7);
                start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        chk("up_done_pulse", done, 1);
        chk("up_done_fword", fword, 0);
        chk("up_done_busy", busy, 0);
        tick();
        chk("up_done_once", done, 0);

        // Ping-pong 1..3, dwell 1
        cfg(2'b11, 3'd1, 3'd3, 16'd1, 12'd1);
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            chk("pp_fword", fword, pp_seq[k]);
            chk("pp_tick", step_tick, 1);
            chk("pp_done", done, 0);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("pp_stop_fword", fword, 0);
        chk("pp_stop_busy", busy, 0);
        chk("pp_stop_done", done, 0);

        // Phase wrap: continuous up-wrap 1..2, dwell 0, p_step 0xC00
        cfg(2'b10, 3'd1, 3'd2, 16'd0, 12'hC00);
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            chk("wrap_pword", pword, wrap_p[k]);
            chk("wrap_fword", fword, wrap_f[k]);
            chk("wrap_tick", step_tick, 1);
            tick();
        end

        // Reset mid-sweep, then a single-word sweep at f_min=1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_fword", fword, 0);
        chk("mrst_pword", pword, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_tick", step_tick, 0);
        chk("mrst_state", state_dbg, 0);
        cfg(2'b00, 3'd1, 3'd1, 16'd0, 12'd9);
        pulse_start();
        chk("one_fword", fword, 1);
        chk("one_busy", busy, 1);
        tick();
        chk("one_done", done, 1);
        chk("one_fword_end", fword, 0);

        // Stop on the dwell-expiry cycle in single-down mode
        cfg(2'b01, 3'd2, 3'd4, 16'd2, 12'd5);
        pulse_start();
        chk("dn_fword0", fword, 4);
        chk("dn_pword0", pword, 0);
        tick();
        chk("dn_fword1", fword, 4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("dn_stop_fword", fword, 0);
        chk("dn_stop_pword", pword, 0);
        chk("dn_stop_busy", busy, 0);
        chk("dn_stop_done", done, 0);
        tick();
        chk("dn_stop_done2", done, 0);

        // Start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_fword", fword, 0);
        chk("ss_cfg_err", cfg_err, 0);

        // Invalid config, sticky flag, then a valid restart
        cfg(2'b00, 3'd4, 3'd2, 16'd2, 12'd1);
        pulse_start();
        chk("err_cfg_err", cfg_err, 1);
        chk("err_busy", busy, 0);
        chk("err_fword", fword, 0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("err_sticky", cfg_err, 1);
        cfg(2'b00, 3'd0, 3'd3, 16'd2, 12'd1);
        pulse_start();
        chk("err_fmin0", cfg_err, 1);
        chk("err_fmin0_busy", busy, 0);
        cfg(2'b00, 3'd3, 3'd3, 16'd2, 12'd1);
        pulse_start();
        chk("ok_cfg_err", cfg_err, 0);
        chk("ok_fword", fword, 3);
        chk("ok_busy", busy, 1);
        tick();
        chk("ok_hold", fword, 3);
        chk("ok_tick_low", step_tick, 0);
        tick();
        chk("ok_done", done, 1);
        chk("ok_fword_end", fword, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
